// File: rtl/ram64_pkg.sv
// Shared constants, word type and the 8-way load decoder for the Hack RAM blocks.
// Buses are MSB-first ([0:15]); address vectors are LSB-first (address[0] is the LSB).
package ram64_pkg;
   localparam int WORD_W   = 16;
   localparam int RAM8_AW  = 3;
   localparam int RAM64_AW = 6;
   localparam int RAM8_N   = 1 << RAM8_AW;

   typedef logic [0:WORD_W-1] word_t;

   // sel[0] picks even/odd, sel[1] the pair, sel[2] the half
   function automatic logic [RAM8_AW-1:0] sel_idx(input logic [0:RAM8_AW-1] sel);
      return {sel[2], sel[1], sel[0]};
   endfunction

   function automatic logic [RAM8_N-1:0] dmux8way(input logic ld, input logic [0:RAM8_AW-1] sel);
      logic [RAM8_N-1:0] o;
      o = '0;
      o[sel_idx(sel)] = ld;
      return o;
   endfunction
endpackage

// File: rtl/ram64_if.sv
// Data/address bus of the 64-word RAM, as seen from the CPU (master) and the RAM (slave).
interface ram64_if;
   ram64_pkg::word_t                      in;
   logic                                  load;
   logic [0:ram64_pkg::RAM64_AW-1]        address;
   ram64_pkg::word_t                      out;

   modport master (output in, output load, output address, input out);
   modport slave  (input in, input load, input address, output out);
endinterface

// File: rtl/ram64_ram8.sv
// Eight 16-bit registers with decoded load and combinational 8-way read mux.
module ram64_ram8
   import ram64_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  word_t                in,
   input  logic                 load,
   input  logic [0:RAM8_AW-1]   address,
   output word_t                out
);
   word_t             regs [RAM8_N];
   logic [RAM8_N-1:0] ld;

   assign ld = dmux8way(load, address);

   // reset wins over any decoded load
   always_ff @(posedge clk) begin
      for (int w = 0; w < RAM8_N; w++) begin
         if (reset)      regs[w] <= '0;
         else if (ld[w]) regs[w] <= in;
      end
   end

   assign out = regs[sel_idx(address)];
endmodule

// File: rtl/ram64.sv
// 64 x 16 RAM: eight ram8 banks, load steered by address[3:5], bank outputs muxed back out.
module ram64
   import ram64_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64
) (
   input  logic    clk,
   input  logic    reset,
   ram64_if.slave  bus
);
   localparam int NUM_BANKS = DEPTH / RAM8_N;

   logic [0:WIDTH-1]     bank_out [NUM_BANKS];
   logic [NUM_BANKS-1:0] bank_ld;
   logic [0:RAM8_AW-1]   word_sel;
   logic [0:RAM8_AW-1]   bank_sel;

   assign word_sel = bus.address[0:2];
   assign bank_sel = bus.address[3:5];
   assign bank_ld  = dmux8way(bus.load, bank_sel);

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      ram64_ram8 u_ram8 (
         .clk     (clk),
         .reset   (reset),
         .in      (bus.in),
         .load    (bank_ld[b]),
         .address (word_sel),
         .out     (bank_out[b])
      );
   end

   assign bus.out = bank_out[sel_idx(bank_sel)];
endmodule
